seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, DIV/REM for the execute stage.
// Latency: WIDTH+2 cycles from accepted start to done (2 cycles when dividing by zero).
// Backpressure: start is only honoured in IDLE/DONE; busy stalls the caller, no queuing.
// Optional build macro DIV_SIGNED_EN enables two's-complement operation via is_signed.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_div;      // divisor magnitude
    logic [WIDTH-1:0] r_a;        // dividend as given, for the divide-by-zero remainder
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Remainder shifted left with the next dividend bit; a clear top bit of the
    // trial difference means the divisor fits (remainder < divisor keeps this exact).
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};

`ifdef DIV_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg = is_signed & A[WIDTH-1];
    assign w_b_neg = is_signed & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? ({WIDTH{1'b0}} - A) : A;
    assign w_b_mag = w_b_neg ? ({WIDTH{1'b0}} - B) : B;
    // Most-negative / -1 needs no special case: the magnitude quotient is 2^(WIDTH-1),
    // which already reads back as the most-negative value when left un-negated.
    assign w_q_fix = r_neg_q ? ({WIDTH{1'b0}} - r_dvd) : r_dvd;
    assign w_r_fix = r_neg_r ? ({WIDTH{1'b0}} - r_rem) : r_rem;

    // Sign flags captured with the operands: quotient sign is the XOR, remainder follows A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_a_mag            = A;
    assign w_b_mag            = B;
    assign w_q_fix            = r_dvd;
    assign w_r_fix            = r_rem;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a zero divisor skips the iterations entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (B == '0) ? S_FIX : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC:  w_next = (r_cnt == '0) ? S_FIX : S_CALC;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_CALC:  busy = 1'b1;
            S_FIX:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, one shift-subtract step per CALC cycle, result load in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_div  <= '0;
            r_a    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_remo <= '0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_dvd <= w_a_mag;
            r_div <= w_b_mag;
            r_a   <= A;
            r_cnt <= CW'(WIDTH - 1);
        end else if (r_state == S_CALC) begin
            r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == S_FIX) begin
            if (r_div == '0) begin
                r_quot <= '1;
                r_remo <= r_a;
            end else begin
                r_quot <= w_q_fix;
                r_remo <= w_r_fix;
            end
        end
    end

    assign Quotient  = r_quot;
    assign Remainder = r_remo;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider with a queue-based scoreboard.
// Expected results come from plain integer division in a reference function.
// A negedge monitor pops one expectation per done pulse and checks result, latency and busy length.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         busy;
    logic         done;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           due;
        int           busy_len;
    } exp_t;

    exp_t q_exp[$];
    int   tests;
    int   fails;
    int   pcnt;
    int   busy_cnt;
    int   done_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: integer division with the divide-by-zero convention.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            if (sg) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                if (q_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got done=1 expected no pending op");
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("quotient", Quotient, e.q);
                    chk("remainder", Remainder, e.r);
                    chk("done_cycle", W'(pcnt), W'(e.due));
                    chk("busy_cycles", W'(busy_cnt), W'(e.busy_len));
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive a start in the current cycle (called right after a negedge) and log the expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        exp_t e;
        start     = 1'b1;
        A         = a;
        B         = b;
        is_signed = sg;
        model(a, b, sg, e.q, e.r);
        e.due      = pcnt + ((b == 0) ? 2 : W + 2);
        e.busy_len = (b == 0) ? 1 : W + 1;
        q_exp.push_back(e);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        @(negedge clk);
        issue(a, b, sg);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        int           seen0;
        tests = 0; fails = 0; pcnt = 0; busy_cnt = 0; done_seen = 0;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_quotient", Quotient, '0);
        chk("reset_remainder", Remainder, '0);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);

        // Directed cases.
        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'd5, 32'd0, 1'b0);
        run_op(32'd5, 32'd0, 1'b1);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'd3, 32'd10, 1'b0);

        // Starts while busy are ignored; a start held in the DONE cycle is accepted.
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 20);
            if (c == 5) begin A = 32'd50; B = 32'd3; end
        end
        wait_done();
        issue(32'd9, 32'd3, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        chk("hold_quotient", Quotient, 32'd3);
        chk("hold_remainder", Remainder, 32'd0);

        // Reset in the middle of an operation aborts it with no done pulse.
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b0);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        q_exp.delete();
        #1;
        chk("abort_quotient", Quotient, '0);
        chk("abort_remainder", Remainder, '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        seen0 = done_seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_done", W'(done_seen), W'(seen0));

        // Randomised operations, including zero and small divisors and random signedness.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = ~W'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        if (q_exp.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_ops: got %0d outstanding expected 0", q_exp.size());
        end
        model(32'd0, 32'd0, 1'b0, mq, mr);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

endmodule
